// File: rtl/delta_integrator.sv
// Delta-to-absolute sample reconstruction for the SPI receive path.
// Seed word starts each frame; following deltas are accumulated mod 2^WIDTH.
module delta_integrator #(
  parameter int WIDTH     = 10,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             ovf
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    SEED,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum;
  logic             accept;
  logic             take;
  logic             wrap;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign sum      = acc + in_data;

  // Signed overflow: operands agree in sign, result does not.
  assign wrap = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                (sum[WIDTH-1] != acc[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      state     <= SEED;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (take && !accept) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        unique case (state)
          SEED: begin
            acc      <= in_data;
            out_data <= in_data;
            if (FRAME_LEN == 1) begin
              out_last <= 1'b1;
              cnt      <= '0;
            end else begin
              out_last <= 1'b0;
              cnt      <= CW'(1);
              state    <= RUN;
            end
          end
          RUN: begin
            acc      <= sum;
            out_data <= sum;
            if (wrap) begin
              ovf <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              out_last <= 1'b1;
              cnt      <= '0;
              state    <= SEED;
            end else begin
              out_last <= 1'b0;
              cnt      <= cnt + 1'b1;
            end
          end
          default: begin
            state <= SEED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delta_integrator.sv
// Directed bench for delta_integrator: FRAME_LEN=4 and FRAME_LEN=1 instances.
// Expected samples are hand-computed from the delta sequences.
module tb_delta_integrator;

  localparam int W = 10;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         ovf;

  logic         v1;
  logic         r1;
  logic [W-1:0] d1;
  logic         ov1;
  logic [W-1:0] od1;
  logic         ol1;
  logic         of1;

  int checks = 0;
  int errors = 0;

  delta_integrator #(.WIDTH(W), .FRAME_LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .ovf      (ovf)
  );

  delta_integrator #(.WIDTH(W), .FRAME_LEN(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (1'b0),
    .in_valid (v1),
    .in_ready (r1),
    .in_data  (d1),
    .out_valid(ov1),
    .out_ready(1'b1),
    .out_data (od1),
    .out_last (ol1),
    .ovf      (of1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sdata(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Present one word, step a clock, check the registered output.
  task automatic push(input string tag, input int d,
                      input int exp, input int last);
    in_valid = 1'b1;
    in_data  = W'(d);
    @(posedge clk); #1;
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".data"}, sdata(out_data), exp);
    chk({tag, ".last"}, int'(out_last), last);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  int v6 [3] = '{3, -4, 9};

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    v1        = 1'b0;
    d1        = '0;
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.ready", int'(in_ready), 1);
    chk("rst.data", sdata(out_data), 0);
    chk("rst.ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic frame
    push("t1.0", 5, 5, 0);
    push("t1.1", 3, 8, 0);
    push("t1.2", -2, 6, 0);
    push("t1.3", -6, 0, 1);
    chk("t1.ovf", int'(ovf), 0);
    idle();
    chk("t1.drop", int'(out_valid), 0);

    // 2: wrap sets sticky ovf
    push("t2.0", 511, 511, 0);
    push("t2.1", 1, -512, 0);
    chk("t2.ovf", int'(ovf), 1);
    push("t2.2", 0, -512, 0);
    push("t2.3", 0, -512, 1);
    push("t2.4", 0, 0, 0);
    push("t2.5", 0, 0, 0);
    chk("t2.sticky", int'(ovf), 1);
    push("t2.6", 0, 0, 0);
    push("t2.7", 0, 0, 1);
    idle();

    // 4: clear mid-frame drops word presented with it
    push("t4.0", 5, 5, 0);
    push("t4.1", 3, 8, 0);
    clear   = 1'b1;
    in_data = W'(-2);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t4.valid", int'(out_valid), 0);
    chk("t4.ovf", int'(ovf), 0);
    push("t4.2", 100, 100, 0);
    push("t4.3", 1, 101, 0);
    clear    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;

    // 3: backpressure holds output, loses nothing
    push("t3.0", 5, 5, 0);
    out_ready = 1'b0;
    in_data   = W'(3);
    #1;
    chk("t3.rdy0", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t3.hold", sdata(out_data), 5);
      chk("t3.hv", int'(out_valid), 1);
      chk("t3.rdy", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3.1", sdata(out_data), 8);
    push("t3.2", -2, 6, 0);
    push("t3.3", -6, 0, 1);
    idle();

    // 5: async reset between edges
    push("t5.0", 5, 5, 0);
    push("t5.1", 3, 8, 0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5.valid", int'(out_valid), 0);
    chk("t5.data", sdata(out_data), 0);
    chk("t5.last", int'(out_last), 0);
    chk("t5.ovf", int'(ovf), 0);
    chk("t5.ready", int'(in_ready), 1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("t5.2", 7, 7, 0);
    push("t5.3", 1, 8, 0);
    idle();

    // 6: single-word frames
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1;
      d1 = W'(v6[i]);
      @(posedge clk); #1;
      chk("t6.valid", int'(ov1), 1);
      chk("t6.data", sdata(od1), v6[i]);
      chk("t6.last", int'(ol1), 1);
      chk("t6.ovf", int'(of1), 0);
    end
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("t6.ready", int'(r1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
